// File: rtl/pmu_hex_tx_framer.sv
// Queues PMU counter samples and serialises each one as uppercase ASCII hex
// (MSB nibble first) followed by a two-byte trailer on an AXI-Stream byte port.
module pmu_hex_tx_framer #(
   parameter int unsigned COUNTERSIZE = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter logic [7:0]  LINEFEED    = 8'h0A,
   parameter logic [7:0]  NEWLINE     = 8'h0D
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [COUNTERSIZE-1:0] in_value,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   busy,
   output logic                   drop_pulse,
   output logic [7:0]             drop_count
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned ND = COUNTERSIZE / 4;

   typedef enum logic [1:0] {IDLE, DIGIT, LF, CR} state_t;

   logic [COUNTERSIZE-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]          r_wr_ptr;
   logic [PW-1:0]          r_rd_ptr;
   logic [CW-1:0]          r_count;
   state_t                 r_state;
   state_t                 w_next;
   logic [COUNTERSIZE-1:0] r_shift;
   logic [3:0]             r_digit;
   logic                   r_drop_pulse;
   logic [7:0]             r_drop_count;
   logic                   w_push;
   logic                   w_drop;
   logic                   w_pop;
   logic [3:0]             w_nibble;
   logic [7:0]             w_ascii;

   // in_ready looks only at current occupancy, so a same-cycle pop never frees a slot
   assign in_ready   = (r_count != CW'(FIFO_DEPTH));
   assign w_push     = in_valid & in_ready;
   assign w_drop     = in_valid & ~in_ready;
   assign w_pop      = (r_state == IDLE) && (r_count != '0);
   assign busy       = (r_state != IDLE) || (r_count != '0);
   assign drop_pulse = r_drop_pulse;
   assign drop_count = r_drop_count;

   assign w_nibble = r_shift[COUNTERSIZE-1 -: 4];
   assign w_ascii  = (w_nibble < 4'd10) ? (8'h30 + {4'h0, w_nibble})
                                        : (8'h37 + {4'h0, w_nibble});

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= in_value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = 8'h00;
      case (r_state)
         IDLE: begin
            if (w_pop) w_next = DIGIT;
         end
         DIGIT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = w_ascii;
            if (m_axis_tready && (r_digit == '0)) w_next = LF;
         end
         LF: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = LINEFEED;
            if (m_axis_tready) w_next = CR;
         end
         CR: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = NEWLINE;
            if (m_axis_tready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift <= '0;
         r_digit <= '0;
      end else if (w_pop) begin
         r_shift <= r_mem[r_rd_ptr];
         r_digit <= 4'(ND - 1);
      end else if ((r_state == DIGIT) && m_axis_tready) begin
         r_shift <= r_shift << 4;
         if (r_digit != '0) r_digit <= r_digit - 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop_pulse <= 1'b0;
         r_drop_count <= '0;
      end else begin
         r_drop_pulse <= w_drop;
         if (w_drop && (r_drop_count != 8'hFF)) r_drop_count <= r_drop_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_pmu_hex_tx_framer.sv
// Directed and randomized checks of the hex framer at 8- and 16-bit sample widths
// against a string-based formatting model.
module tb_pmu_hex_tx_framer;

   typedef logic [7:0] bq_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  a_val = '0;
   logic        a_valid = 1'b0, a_ready, a_tvalid, a_tready = 1'b0, a_busy, a_dp;
   logic [7:0]  a_tdata, a_dc;
   logic [15:0] b_val = '0;
   logic        b_valid = 1'b0, b_ready, b_tvalid, b_tready = 1'b0, b_busy, b_dp;
   logic [7:0]  b_tdata, b_dc;

   int checks = 0;
   int failures = 0;
   bq_t a_got, a_exp, b_got, b_exp;

   pmu_hex_tx_framer #(.COUNTERSIZE(8), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .in_value(a_val), .in_valid(a_valid), .in_ready(a_ready),
      .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(a_tready),
      .busy(a_busy), .drop_pulse(a_dp), .drop_count(a_dc));

   pmu_hex_tx_framer #(.COUNTERSIZE(16), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .in_value(b_val), .in_valid(b_valid), .in_ready(b_ready),
      .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
      .busy(b_busy), .drop_pulse(b_dp), .drop_count(b_dc));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && a_tvalid && a_tready) a_got.push_back(a_tdata);
      if (!rst && b_tvalid && b_tready) b_got.push_back(b_tdata);
   end

   // Expected frame: nd uppercase hex digits MSB first, then LF, CR.
   function automatic bq_t fmt(input logic [31:0] v, input int nd);
      bq_t   r;
      string hx;
      int    nib;
      hx = "0123456789ABCDEF";
      for (int i = 0; i < nd; i++) begin
         nib = int'((v >> (4 * (nd - 1 - i))) & 32'hF);
         r.push_back(hx[nib]);
      end
      r.push_back(8'h0A);
      r.push_back(8'h0D);
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp_a(input string tag);
      chk({tag, "_len"}, a_got.size(), a_exp.size());
      for (int i = 0; i < a_got.size() && i < a_exp.size(); i++) chk(tag, a_got[i], a_exp[i]);
      a_got.delete();
      a_exp.delete();
   endtask

   task automatic cmp_b(input string tag);
      chk({tag, "_len"}, b_got.size(), b_exp.size());
      for (int i = 0; i < b_got.size() && i < b_exp.size(); i++) chk(tag, b_got[i], b_exp[i]);
      b_got.delete();
      b_exp.delete();
   endtask

   task automatic drain_a();
      int n = 0;
      a_tready = 1'b1;
      do begin
         cyc();
         @(negedge clk);
         n++;
      end while (a_busy && n < 200);
      chk("a_drain_done", a_busy, 1'b0);
   endtask

   task automatic do_reset();
      cyc();
      rst = 1'b1;
      a_valid = 1'b0; b_valid = 1'b0; a_tready = 1'b0; b_tready = 1'b0;
      @(negedge clk);
      chk("rst_a_ready", a_ready, 1'b1);
      chk("rst_a_busy", a_busy, 1'b0);
      chk("rst_a_tvalid", a_tvalid, 1'b0);
      chk("rst_a_tdata", a_tdata, 8'h00);
      chk("rst_a_dp", a_dp, 1'b0);
      chk("rst_a_dc", a_dc, 8'h00);
      chk("rst_b_ready", b_ready, 1'b1);
      chk("rst_b_busy", b_busy, 1'b0);
      chk("rst_b_tvalid", b_tvalid, 1'b0);
      cyc();
      rst = 1'b0;
      a_got.delete(); a_exp.delete(); b_got.delete(); b_exp.delete();
   endtask

   // Primer sample occupies the stalled frame engine, then four more fill the queue.
   task automatic fill_a(input logic [7:0] base);
      a_tready = 1'b0;
      cyc(); a_val = base; a_valid = 1'b1;
      cyc(); a_valid = 1'b0;
      a_exp = {a_exp, fmt(32'(base), 2)};
      for (int k = 1; k <= 4; k++) begin
         cyc(); a_val = base + 8'(k); a_valid = 1'b1;
         a_exp = {a_exp, fmt(32'(base + 8'(k)), 2)};
      end
      cyc(); a_valid = 1'b0;
      @(negedge clk);
      chk("fill_full_ready", a_ready, 1'b0);
   endtask

   initial begin
      int          n;
      logic        stall, found, pdrop;
      logic [7:0]  pd;
      int          mdc;

      do_reset();

      // 8-bit sample 0x3C, tready high, two-cycle latency
      a_tready = 1'b1;
      cyc(); a_val = 8'h3C; a_valid = 1'b1; @(negedge clk);
      chk("lat_n0_tvalid", a_tvalid, 1'b0);
      cyc(); a_valid = 1'b0; @(negedge clk);
      chk("lat_n1_tvalid", a_tvalid, 1'b0);
      chk("lat_n1_busy", a_busy, 1'b1);
      cyc(); @(negedge clk);
      chk("lat_n2_tvalid", a_tvalid, 1'b1);
      chk("lat_n2_tdata", a_tdata, 8'h33);
      drain_a();
      a_exp = {8'h33, 8'h43, 8'h0A, 8'h0D};
      cmp_a("frame_3C");

      // 16-bit sample 0xA09F with tready toggling every cycle
      b_tready = 1'b1;
      cyc(); b_val = 16'hA09F; b_valid = 1'b1; @(negedge clk);
      cyc(); b_valid = 1'b0; @(negedge clk);
      n = 0; stall = 1'b0; pd = '0;
      do begin
         cyc(); b_tready = ~b_tready; @(negedge clk);
         if (stall) chk("b_stall_hold", b_tdata, pd);
         stall = b_tvalid && !b_tready;
         pd = b_tdata;
         n++;
      end while (b_busy && n < 60);
      chk("b_drain_done", b_busy, 1'b0);
      b_exp = {8'h41, 8'h30, 8'h39, 8'h46, 8'h0A, 8'h0D};
      cmp_b("frame_A09F");

      // Overflow: primer stalls in flight, values 1..5 pulsed, 5 is dropped
      a_tready = 1'b0;
      cyc(); a_val = 8'h5A; a_valid = 1'b1;
      cyc(); a_valid = 1'b0;
      a_exp = fmt(32'h5A, 2);
      for (int k = 1; k <= 5; k++) begin
         cyc(); a_val = 8'(k); a_valid = 1'b1; @(negedge clk);
         chk($sformatf("ovf_ready_%0d", k), a_ready, (k < 5) ? 1'b1 : 1'b0);
         if (k < 5) a_exp = {a_exp, fmt(32'(k), 2)};
      end
      cyc(); a_valid = 1'b0; @(negedge clk);
      chk("ovf_dp", a_dp, 1'b1);
      chk("ovf_dc", a_dc, 8'd1);
      cyc(); @(negedge clk);
      chk("ovf_dp_clear", a_dp, 1'b0);
      chk("ovf_dc_hold", a_dc, 8'd1);
      drain_a();
      cmp_a("ovf_frames");

      // Push into a full queue in the same cycle as an IDLE pop
      fill_a(8'h10);
      a_tready = 1'b1;
      n = 0; found = 1'b0;
      do begin
         cyc(); @(negedge clk);
         found = a_tvalid && (a_tdata == 8'h0D);
         n++;
      end while (!found && n < 30);
      chk("popdrop_found_cr", found, 1'b1);
      cyc(); a_val = 8'hEE; a_valid = 1'b1; @(negedge clk);
      chk("popdrop_ready", a_ready, 1'b0);
      chk("popdrop_idle", a_tvalid, 1'b0);
      cyc(); a_valid = 1'b0; @(negedge clk);
      chk("popdrop_dp", a_dp, 1'b1);
      chk("popdrop_dc", a_dc, 8'd2);
      chk("popdrop_ready_after", a_ready, 1'b1);
      drain_a();
      cmp_a("popdrop_frames");

      // Saturation of the drop counter
      fill_a(8'h50);
      for (int k = 0; k < 300; k++) begin
         cyc(); a_val = 8'($urandom); a_valid = 1'b1;
      end
      cyc(); a_valid = 1'b0; @(negedge clk);
      chk("sat_dp", a_dp, 1'b1);
      chk("sat_dc", a_dc, 8'd255);
      cyc(); @(negedge clk);
      chk("sat_dc_hold", a_dc, 8'd255);
      do_reset();

      // Reset mid-frame after two bytes with two samples queued
      cyc(); a_val = 8'hC1; a_valid = 1'b1;
      cyc(); a_valid = 1'b0;
      cyc(); a_val = 8'hC2; a_valid = 1'b1;
      cyc(); a_val = 8'hC3;
      cyc(); a_valid = 1'b0;
      cyc(); a_tready = 1'b1;
      cyc();
      cyc();
      chk("midrst_bytes_before", a_got.size(), 2);
      rst = 1'b1;
      #1;
      chk("midrst_tvalid", a_tvalid, 1'b0);
      chk("midrst_busy", a_busy, 1'b0);
      chk("midrst_ready", a_ready, 1'b1);
      cyc(); rst = 1'b0;
      repeat (10) begin cyc(); @(negedge clk); end
      chk("midrst_no_bytes", a_got.size(), 2);
      chk("midrst_idle_busy", a_busy, 1'b0);
      a_got.delete();
      cyc(); a_val = 8'h7E; a_valid = 1'b1;
      cyc(); a_valid = 1'b0;
      a_exp = fmt(32'h7E, 2);
      drain_a();
      cmp_a("midrst_new_frame");

      // Randomized traffic and backpressure
      mdc = 0; pdrop = 1'b0;
      for (int t = 0; t < 400; t++) begin
         cyc();
         a_valid  = ($urandom % 3) == 0;
         a_val    = 8'($urandom);
         a_tready = ($urandom % 4) != 0;
         @(negedge clk);
         chk("rnd_dp", a_dp, pdrop);
         chk("rnd_dc", a_dc, 8'(mdc));
         pdrop = a_valid && !a_ready;
         if (a_valid && a_ready) a_exp = {a_exp, fmt(32'(a_val), 2)};
         if (pdrop && mdc < 255) mdc++;
      end
      cyc(); a_valid = 1'b0;
      drain_a();
      cmp_a("rnd_stream");
      chk("rnd_dc_final", a_dc, 8'(mdc));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
